bus_arbiter4: RTL and testbench
===============================

# bus_arbiter4

Four-requester round-robin arbiter that owns the select of the shared 4-input datapath multiplexer (`mux4`). Grants exactly one requester at a time and drives the mux `sel` code for the granted source. Enforces a bounded hold time so no requester can starve the others. Sits between the requesting units and the shared bus.

## Interface
- `MAXHOLD`, default 8: maximum consecutive grant cycles per tenure; legal range 2..256.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  4  request per source; bit i = mux input i.
- `done`  in  4  end-of-transfer strobe per source; only the owner's bit is honoured.
- `gnt`  out  4  registered one-hot grant, or all zero.
- `sel`  out  2  registered mux select; equals the owner's index while granted.
- `busy`  out  1  high while any grant is active.
- `timeout`  out  1  one-cycle pulse when a tenure is ended by `MAXHOLD`.

## Operation
- States: IDLE and GRANT. `owner[1:0]` is the current/last granted index. `ptr[1:0]` is the last granted index, used for the round-robin start. `hold` counter is ceil(log2(MAXHOLD)) bits.
- Arbitration (combinational, used in IDLE and on release):
  - Search order is ptr+1, ptr+2, ptr+3, ptr, mod 4.
  - The first index with `req` high wins.
  - The previous owner is therefore lowest priority.
- IDLE:
  - If any `req` is high, then at the next edge: gnt = onehot(winner), sel = winner, ptr = winner, hold = 0, go to GRANT.
  - Otherwise remain in IDLE. gnt = 0; `sel` keeps its last value.
- GRANT: release condition is `done[owner]`, or `req[owner]` low, or hold == MAXHOLD-1.
  - On release with another eligible request: re-arbitrate in the same edge and grant the winner back-to-back, with no idle cycle.
  - On release with no other requests: go to IDLE with gnt = 0. If `req[owner]` is still high, it is re-granted via IDLE on the following edge.
  - If no release: hold += 1; gnt and sel are unchanged.
- `timeout` is asserted for exactly the cycle after the edge where release happened by hold == MAXHOLD-1 and neither `done[owner]` nor a `req[owner]` drop occurred.
- `done` bits of non-owners are ignored.
- `req` changes of non-owners never preempt the owner.
- `busy` = (state == GRANT). `gnt` is never multi-hot. Whenever `gnt` is non-zero, `sel` always matches it.

## Timing
- Reset values (applied asynchronously): state IDLE, gnt 0000, sel 00, busy 0, timeout 0, hold 0, ptr 11 (so source 0 has first priority).
- Reset asserted mid-grant drops gnt immediately, without waiting for an edge. After reset, the bus is re-arbitrated from source 0.
- Latency from request to grant: `req` high before edge N gives `gnt`/`sel` valid after edge N. This is 1 cycle from IDLE.
- Release latency: `done[owner]` high before edge N means the grant changes or drops after edge N.
- Maximum tenure: MAXHOLD cycles of `gnt` high.
- Worst-case wait for a continuously requesting source: 3·MAXHOLD cycles.
- All outputs are registered. There are no combinational paths from `req`/`done` to outputs.

## Test plan
- Reset: hold `rst` high, then set req=1111 and release `rst`. Required: while in reset gnt=0000, sel=00, busy=0; after the first edge gnt=0001, sel=00.
- Single source: req=0100 from cycle 0, with `done[2]` pulsed in cycle 3. Required: gnt=0100 and sel=10 after edge 0; gnt=0000 and busy=0 after the edge following the `done` pulse.
- Fairness: req=1111 held, with each owner pulsing `done` on its 2nd granted cycle. Required: grant order 0,1,2,3,0, each held 2 cycles back-to-back, with busy never low.
- Timeout: MAXHOLD=8, req=0010 held with no `done`, and req[3] raised at cycle 2. Required: gnt=0010 for exactly 8 cycles, then gnt=1000 plus a single-cycle timeout=1.
- Ignored and simultaneous events:
  - Owner 1 with `done[0]` pulsed: gnt stays 0010.
  - `done[1]` pulsed in the same cycle that req[2] rises: gnt=0100 on the next edge.
- Async reset mid-grant: assert `rst` between edges while gnt=0100. Required: gnt=0000 before the next edge; after release with req=0101, grant goes to source 0 first.

Source files
------------

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-source round-robin arbiter driving the shared mux4 select.
// Each tenure is bounded to MAXHOLD cycles. The previous owner takes the lowest priority.
module bus_arbiter4 #(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned HW = (MAXHOLD > 2) ? $clog2(MAXHOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        r_state;
    logic [3:0]    r_gnt;
    logic [1:0]    r_sel;
    logic [1:0]    r_ptr;
    logic [HW-1:0] r_hold;
    logic          r_busy;
    logic          r_timeout;

    logic [3:0]    w_req_eff;
    logic [1:0]    w_winner;
    logic [1:0]    w_idx;
    logic          w_any;
    logic          w_req_own;
    logic          w_done_own;
    logic          w_hold_max;
    logic          w_release;

    // r_ptr holds the current owner while in GRANT.
    assign w_req_own  = req[r_ptr];
    assign w_done_own = done[r_ptr];
    assign w_hold_max = (r_hold == HOLD_LAST);
    assign w_release  = w_done_own | ~w_req_own | w_hold_max;

    // A releasing owner is excluded so that it cannot win back-to-back against nobody.
    assign w_req_eff = (r_state == ST_GRANT) ? (req & ~(4'b0001 << r_ptr)) : req;

    // Round-robin search over ptr+1, ptr+2, ptr+3, ptr; the first requester found wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_any && w_req_eff[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Grant state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 4'b0000;
            r_sel     <= 2'b00;
            r_ptr     <= 2'b11;
            r_hold    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_ptr   <= w_winner;
                        r_hold  <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_gnt  <= 4'b0000;
                        r_busy <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_timeout <= w_hold_max & ~w_done_own & w_req_own;
                        r_hold    <= '0;
                        if (w_any) begin
                            r_gnt  <= 4'b0001 << w_winner;
                            r_sel  <= w_winner;
                            r_ptr  <= w_winner;
                            r_busy <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed testbench for bus_arbiter4 with MAXHOLD = 8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_total;
    int n_bad;

    bus_arbiter4 #(.MAXHOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report any mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle: one rising edge, then return at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] oh;
    int         order [5];

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        order = '{0, 1, 2, 3, 0};

        // Reset state, then first grant to source 0.
        @(negedge clk);
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_to", 32'(timeout), 32'h0);
        req = 4'b1111;
        tick();
        chk("rst_hold_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_sel", 32'(sel), 32'h0);
        chk("first_busy", 32'(busy), 32'h1);

        // Single source with a done pulse in cycle 3.
        do_reset();
        req = 4'b0100;
        tick();
        chk("single_gnt0", 32'(gnt), 32'h4);
        chk("single_sel0", 32'(sel), 32'h2);
        tick();
        tick();
        chk("single_gnt2", 32'(gnt), 32'h4);
        done = 4'b0100;
        tick();
        done = 4'b0000;
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_busy", 32'(busy), 32'h0);
        tick();
        chk("single_regnt", 32'(gnt), 32'h4);
        chk("single_regnt_sel", 32'(sel), 32'h2);

        // Fairness: all request, each owner releases on its 2nd cycle.
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            done = 4'b0000;
            oh = 4'b0001 << order[i];
            chk("fair_gnt_a", 32'(gnt), 32'(oh));
            chk("fair_sel_a", 32'(sel), 32'(order[i]));
            chk("fair_busy_a", 32'(busy), 32'h1);
            tick();
            chk("fair_gnt_b", 32'(gnt), 32'(oh));
            chk("fair_busy_b", 32'(busy), 32'h1);
            done = oh;
            tick();
        end
        done = 4'b0000;
        chk("fair_next", 32'(gnt), 32'h2);

        // Timeout: source 1 holds for MAXHOLD cycles, source 3 waits.
        do_reset();
        req = 4'b0010;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_hold_gnt", 32'(gnt), 32'h2);
            chk("to_hold_pulse", 32'(timeout), 32'h0);
            if (i == 1) req = 4'b1010;
            tick();
        end
        chk("to_new_gnt", 32'(gnt), 32'h8);
        chk("to_new_sel", 32'(sel), 32'h3);
        chk("to_pulse", 32'(timeout), 32'h1);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'h0);
        chk("to_keep_gnt", 32'(gnt), 32'h8);

        // Non-owner done is ignored; owner done plus a new request hands over back-to-back.
        do_reset();
        req = 4'b0010;
        tick();
        chk("ign_gnt0", 32'(gnt), 32'h2);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        chk("ign_gnt1", 32'(gnt), 32'h2);
        done = 4'b0010;
        req  = 4'b0110;
        tick();
        done = 4'b0000;
        chk("simul_gnt", 32'(gnt), 32'h4);
        chk("simul_sel", 32'(sel), 32'h2);
        chk("simul_busy", 32'(busy), 32'h1);
        chk("simul_to", 32'(timeout), 32'h0);

        // Asynchronous reset between edges while source 2 is granted.
        #1;
        rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        req = 4'b0101;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_sel", 32'(sel), 32'h0);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        chk("post_rst_next", 32'(gnt), 32'h4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
